bram_fifo: RTL and testbench

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram_fifo_pkg.sv | 11 +
 rtl/bram_fifo_bram_1r1w.sv | 54 +++++
 rtl/bram_fifo.sv | 112 +++++++++++
 tb/tb_bram_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the block-RAM backed FIFO.
package bram_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Occupancy count at the default depth: needs one bit more than the address
  // so that a completely full RAM plus the output stages can be represented.
  typedef logic [DEFAULT_ADDR_WIDTH:0] count_t;

endpackage

// File: rtl/bram_fifo_bram_1r1w.sv
// Simple dual-port RAM: one write port with per-column enables, one read port
// with a registered output. The read register holds whenever a write happens
// in the same cycle (no-change behaviour).
module bram_1r1w
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_COL    = 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [NUM_COL-1:0]    wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int COL_WIDTH = DATA_WIDTH / NUM_COL;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Column-masked write into the storage array (RAM contents are never reset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (wr_be[c]) begin
          mem_q[wr_addr][c*COL_WIDTH +: COL_WIDTH] <= wr_data[c*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  // Read register only loads on a read cycle that has no concurrent write.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en && !wr_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Registered read output, behaves like a block-RAM output latch.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_fifo.sv
// FIFO built on a single 1R1W block RAM with a registered output stage.
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both high; push_ready depends only on registered state, and
// pop_valid/pop_data stay stable until the consumer takes the entry.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  logic push_fire;
  logic pop_fire;
  logic rd_issue;

  assign push_ready = (ram_count_q < DEPTH);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = out_valid_q && pop_ready;
  // Prefetch into the output register only when nothing is in flight, the
  // output slot is free (or being freed) and the write port is idle: a push
  // always wins the RAM over a prefetch.
  assign rd_issue   = (ram_count_q != '0) && !push_fire && !rd_pending_q &&
                      (!out_valid_q || pop_fire);

  assign pop_valid  = out_valid_q;
  assign pop_data   = pop_data_q;
  assign count      = ram_count_q + {{ADDR_WIDTH{1'b0}}, rd_pending_q}
                                  + {{ADDR_WIDTH{1'b0}}, out_valid_q};

  // Next-state for pointers, RAM occupancy and the output stage.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    rd_pending_d = rd_issue;
    out_valid_d  = out_valid_q;
    pop_data_d   = pop_data_q;

    if (push_fire) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      ram_count_d = ram_count_q + 1'b1;
    end else if (rd_issue) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ram_count_d = ram_count_q - 1'b1;
    end

    if (pop_fire) begin
      out_valid_d = 1'b0;
    end
    // A read in flight lands in the output register; the issue rule
    // guarantees the slot is empty by then.
    if (rd_pending_q) begin
      out_valid_d = 1'b1;
      pop_data_d  = ram_rd_data;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      rd_pending_q <= 1'b0;
      out_valid_q  <= 1'b0;
      pop_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      rd_pending_q <= rd_pending_d;
      out_valid_q  <= out_valid_d;
      pop_data_q   <= pop_data_d;
    end
  end

  bram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COL    (1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_fire),
    .wr_be   (1'b1),
    .wr_addr (wr_ptr_q),
    .wr_data (push_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_bram_fifo.sv
// Self-checking bench for bram_fifo: directed latency/full/wrap/priority/reset
// scenarios plus a long random run, all scored against a reference queue.
module tb_bram_fifo;
  import bram_fifo_pkg::*;

  localparam int DW    = DEFAULT_DATA_WIDTH;
  localparam int AW    = DEFAULT_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  count_t        count;

  bram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_pass;
  logic          last_push_fire;
  logic          prev_pop_valid;
  logic          prev_pop_fire;
  logic [DW-1:0] prev_pop_data;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Per-cycle scoring at the falling edge, before the state update.
  task automatic sample();
    logic push_fire;
    logic pop_fire;
    push_fire = push_valid && push_ready;
    pop_fire  = pop_valid && pop_ready;
    check("count_vs_model", DW'(count), DW'(exp_q.size()));
    if (exp_q.size() < DEPTH) check("push_ready_not_full", DW'(push_ready), 1);
    if (exp_q.size() == 0) check("pop_valid_empty", DW'(pop_valid), 0);
    if (prev_pop_valid && !prev_pop_fire) begin
      check("pop_valid_hold", DW'(pop_valid), 1);
      check("pop_data_hold", pop_data, prev_pop_data);
    end
    if (pop_fire) begin
      if (exp_q.size() == 0) check("pop_underflow", 1, 0);
      else check("pop_data", pop_data, exp_q.pop_front());
    end
    if (push_fire) exp_q.push_back(push_data);
    last_push_fire = push_fire;
    prev_pop_valid = pop_valid;
    prev_pop_fire  = pop_fire;
    prev_pop_data  = pop_data;
  endtask

  // Driver: apply inputs for one cycle, score it, land just after the next edge.
  task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || count != 0) && n < 200) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    check(tag, DW'(count), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
    #1;
    exp_q.delete();
    prev_pop_valid = 1'b0;
    prev_pop_fire  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_push_fire = 1'b0;
    prev_pop_valid = 1'b0;
    prev_pop_fire  = 1'b0;
    prev_pop_data  = '0;

    // Reset state
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", DW'(count), 0);
    check("rst_pop_valid", DW'(pop_valid), 0);
    check("rst_pop_data", pop_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_push_ready", DW'(push_ready), 1);

    // Single push latency: pop_valid appears three cycles after the push
    step(1'b1, 32'hA5A5_A5A5, 1'b0);
    check("lat_c1_count", DW'(count), 1);
    check("lat_c1_valid", DW'(pop_valid), 0);
    step(1'b0, '0, 1'b0);
    check("lat_c2_count", DW'(count), 1);
    check("lat_c2_valid", DW'(pop_valid), 0);
    step(1'b0, '0, 1'b0);
    check("lat_c3_count", DW'(count), 1);
    check("lat_c3_valid", DW'(pop_valid), 1);
    check("lat_c3_data", pop_data, 32'hA5A5_A5A5);
    step(1'b0, '0, 1'b1);
    check("lat_after_pop_valid", DW'(pop_valid), 0);
    check("lat_after_pop_data", pop_data, 32'hA5A5_A5A5);

    // Fill to full with no pops; a further push is refused
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    check("full_push_ready", DW'(push_ready), 0);
    check("full_count", DW'(count), DEPTH);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("full_held_not_taken", DW'(last_push_fire), 0);
    repeat (4) step(1'b0, '0, 1'b0);
    check("full_count_after_prefetch", DW'(count), DEPTH);
    check("full_head_valid", DW'(pop_valid), 1);
    check("full_head_data", pop_data, 0);
    drain("full_drain");

    // Continuous push/pop, 40 entries across two pointer wraps
    begin
      int pushed;
      int n;
      pushed = 0;
      n = 0;
      while (pushed < 40 && n < 400) begin
        step(1'b1, 32'h1000_0000 + DW'(pushed), 1'b1);
        if (last_push_fire) pushed++;
        n++;
      end
      check("stream_all_pushed", DW'(pushed), 40);
      drain("stream_drain");
    end

    // Pushes block prefetch; reads resume on the first idle push cycle
    step(1'b1, 32'h2000_0000, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    check("prio_head_valid", DW'(pop_valid), 1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 32'h2000_0000 + DW'(i), 1'b1);
      check("prio_no_read_during_push", DW'(pop_valid), 0);
    end
    check("prio_count", DW'(count), 5);
    step(1'b0, '0, 1'b1);
    check("prio_idle1_valid", DW'(pop_valid), 0);
    step(1'b0, '0, 1'b1);
    check("prio_idle2_valid", DW'(pop_valid), 1);
    check("prio_idle2_data", pop_data, 32'h2000_0001);
    drain("prio_drain");

    // Reset mid-operation with a read in flight
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3000_0000 + DW'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    check("midrst_pre_count", DW'(count), 5);
    check("midrst_pre_valid", DW'(pop_valid), 0);
    apply_reset();
    @(negedge clk);
    check("midrst_count", DW'(count), 0);
    check("midrst_valid", DW'(pop_valid), 0);
    check("midrst_data", pop_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_push_ready", DW'(push_ready), 1);
    step(1'b0, '0, 1'b1);
    check("midrst_stays_empty", DW'(count), 0);

    // Random traffic on both sides against the reference queue
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
